prio_encoder_q: RTL
===================

# prio_encoder_q

Sequential 8-to-3 priority encoder: the inverse path to the 3-to-8 decoder. It collects one-hot or multi-hot request pulses on eight lines into a pending register. It then issues them as 3-bit binary codes, one per accepted handshake, highest index first. It sits between request sources and any consumer that needs a binary index stream, such as the decoder-driven full adder datapath or a select bus.

## Interface
- `N_REQ`, 8: number of request lines (fixed at 8 for this revision).
- `CODE_W`, 3: code width, log2(`N_REQ`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 8: request pulses; bit i high for one cycle posts request i; any number of bits may be high together.
- `code` out 3: binary index of issued request; reset 3'b000.
- `valid` out 1: `code` holds an issued request; reset 0.
- `ready` in 1: consumer accepts `code` when `valid & ready`.
- `merged` out 1: one-cycle pulse, a `req` bit hit an already-pending bit; reset 0.
- `idle` out 1: `!valid` and no pending requests; reset 1.

## Operation
- State is `pend[7:0]` (requests not yet issued), the output slot (`code`, `valid`), and `merged`.
- `load = !valid | ready`, meaning the slot is empty or is being accepted this cycle.
- `sel` is the highest set index of `pend`. Bit 7 has the highest priority.
- Each clock with `rst_n = 1`:
  - If `load` and `pend != 0`: `code <= sel`, `valid <= 1`, `pend <= (pend & ~onehot(sel)) | req`.
  - If `load` and `pend == 0`: `valid <= 0`, `pend <= req`. `code` holds its last value.
  - If `!load`: `pend <= pend | req`. `code` and `valid` are held, so `code` is stable while `valid & !ready`.
- `merged <= |(req & pend_kept)`. `pend_kept` is `pend` minus the bit moving to the slot this cycle.
- A request is never lost. A repeat of an already-pending bit is coalesced and flagged by `merged`.
- A `req` bit equal to the index currently in the slot, or being loaded this cycle, re-posts into `pend`. The set wins over the clear. It is issued again later and does not raise `merged`.
- Simultaneous requests are issued in descending index order, one per accepted handshake.
- A higher-index request arriving while a lower one is pending overtakes it at the next load. There is no fairness guarantee.
- Reset mid-operation: on the first edge with `rst_n = 0`, `pend`, `valid`, `code` and `merged` clear. The `req` of that cycle is discarded.
- `idle` is combinational: `!valid & (pend == 0)`.

## Timing
- Latency: `req` at edge n, slot free → `pend` set after edge n → `valid`/`code` after edge n+1. This is two cycles.
- Throughput: one code per cycle while `ready = 1` and `pend` is non-empty. There are no bubbles between back-to-back issues.
- `valid` drops the cycle after the last code is accepted if `pend` is empty.
- `merged` is registered and aligned one cycle after the offending `req`.
- No combinational path from `req` or `ready` to `code` or `valid`.

## Structure
- Shared package `enc_pkg`:
  - `N_REQ` and `CODE_W` constants.
  - `req_vec_t` (`logic [7:0]`) and `code_t` (`logic [2:0]`) typedefs.
  - `onehot8(code_t)` function.
- Sub-module `prio_enc8`: combinational, 8-bit in, 3-bit index out, plus an `any` output. Highest index wins. It is reused by the top-level and unit-tested alone.
- The top-level holds all registers and the load/handshake logic. It is about 150–200 lines including assertions: `code` stable while `valid & !ready`, and `idle` consistent with state.

## Test plan
- Reset: hold `rst_n = 0` with `req = 8'hFF` for 2 cycles → `valid = 0`, `code = 0`, `merged = 0`, `idle = 1`; after release, nothing is issued.
- Single request: `req = 8'h10` for 1 cycle, `ready = 1` → `valid = 1`, `code = 3'd4` exactly 2 cycles later for 1 cycle; then `idle = 1`.
- Burst order: `req = 8'hA5`, `ready = 1` → codes 7, 5, 2, 0 on four consecutive cycles; `valid` then drops.
- Backpressure: `req = 8'h06`, `ready = 0` for 5 cycles → `code = 3'd2` held with `valid = 1` throughout; after `ready = 1`, codes 2 then 1.
- Coalesce and re-post: `req = 8'h01` with `ready = 0` (bit 0 enters the slot), then `req = 8'h08` twice in a row → second `req` gives `merged = 1` one cycle later; with `ready = 1`, codes 0, 3 are issued once each. Then assert `req = 8'h08` on the cycle code 3 is accepted → code 3 is issued again; `merged = 0`.
- Reset mid-stream: `req = 8'hFF`, accept 3 codes (7, 6, 5), pull `rst_n` low for 1 cycle → all state cleared; no further codes after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants, types and helpers for the 8-to-3 priority encoder path.
package enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef logic [N_REQ-1:0]  req_vec_t;
    typedef logic [CODE_W-1:0] code_t;

    // One-hot 8-bit vector with only bit c set.
    function automatic req_vec_t onehot8(input code_t c);
        req_vec_t v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_encoder_q_if.sv
// Request/issue bundle of the sequential priority encoder.
// Handshake: the encoder drives code/valid; a code is transferred on every
// rising clock edge where valid & ready are both high. While valid is high
// and ready is low, code is held stable. ready may be high while valid is low.
interface prio_encoder_q_if;
    import enc_pkg::*;

    req_vec_t req;
    code_t    code;
    logic     valid;
    logic     ready;
    logic     merged;
    logic     idle;

    // Request source / code consumer side.
    modport master (
        output req,
        output ready,
        input  code,
        input  valid,
        input  merged,
        input  idle
    );

    // Encoder side.
    modport slave (
        input  req,
        input  ready,
        output code,
        output valid,
        output merged,
        output idle
    );
endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder: highest set index wins.
module prio_enc8
    import enc_pkg::*;
(
    input  req_vec_t vec_i,
    output code_t    idx_o,
    output logic     any_o
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) begin
                idx_o = code_t'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_q.sv
// Sequential 8-to-3 priority encoder: collects request pulses into a pending
// register and issues them as binary codes, highest index first, one per
// accepted handshake.
module prio_encoder_q
    import enc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    prio_encoder_q_if.slave bus
);

    req_vec_t pend_q, pend_d;
    code_t    code_q, code_d;
    logic     valid_q, valid_d;
    logic     merged_q, merged_d;

    code_t    sel;
    logic     pend_any;
    logic     load;
    logic     take;
    req_vec_t pend_kept;

    prio_enc8 u_enc (
        .vec_i (pend_q),
        .idx_o (sel),
        .any_o (pend_any)
    );

    // Next-state: slot reload, pending update with set-over-clear, merge detect.
    always_comb begin
        load      = !valid_q | bus.ready;
        take      = load & pend_any;
        pend_kept = pend_q;
        code_d    = code_q;
        valid_d   = valid_q;
        if (load) begin
            valid_d = pend_any;
        end
        if (take) begin
            code_d    = sel;
            pend_kept = pend_q & ~onehot8(sel);
        end
        // A request for the index leaving pend this cycle re-posts cleanly
        // because it is ORed in after the clear.
        pend_d   = pend_kept | bus.req;
        merged_d = |(bus.req & pend_kept);
    end

    // State registers; reset discards the request of the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            merged_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            merged_q <= merged_d;
        end
    end

    // Outputs come straight from registers, except idle which is a state decode.
    always_comb begin
        bus.code   = code_q;
        bus.valid  = valid_q;
        bus.merged = merged_q;
        bus.idle   = !valid_q && (pend_q == '0);
    end

    // A presented but unaccepted code must not change.
    a_code_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.ready) |=> (valid_q && code_q == $past(code_q)));

    // idle never coexists with an occupied slot or pending work.
    a_idle_consistent : assert property (@(posedge clk)
        bus.idle |-> (!valid_q && pend_q == '0));

endmodule
